fifo_pop_stream: RTL and testbench

FIFO_POP_STREAM -- requirements
Module: fifo_pop_stream

---
 rtl/fifo_pkg.sv | 13 +
 rtl/skid_buf2.sv | 78 +++++++
 rtl/fifo_pop_stream.sv | 107 ++++++++++
 tb/tb_fifo_pop_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO pop-stream slice.
//   state_t   : pop-stream control state (RUN=0, FLUSH=1)
//   BUF_DEPTH : entries in the output buffer between FIFO read port and stream
package fifo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry buffer with a valid/ready interface on both sides.
// The head entry is a register driving o_out_data/o_out_valid directly.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_clear                  synchronous discard of both entries
//   i_in_valid/o_in_ready    input handshake, i_in_data payload
//   o_out_valid/i_out_ready  output handshake, o_out_data payload (head)
//   o_count                  current occupancy (0..2)
module skid_buf2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_count
);

  logic             head_vld;
  logic             tail_vld;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] tail_data;
  logic             push;
  logic             pop;

  // Full buffer still accepts when the head leaves in the same cycle.
  assign o_in_ready  = !tail_vld || i_out_ready;
  assign push        = i_in_valid && o_in_ready;
  assign pop         = head_vld && i_out_ready;
  assign o_out_valid = head_vld;
  assign o_out_data  = head_data;
  assign o_count     = {1'b0, head_vld} + {1'b0, tail_vld};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_vld  <= 1'b0;
      tail_vld  <= 1'b0;
      head_data <= '0;
      tail_data <= '0;
    end else if (i_clear) begin
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!head_vld) begin
            head_data <= i_in_data;
            head_vld  <= 1'b1;
          end else begin
            tail_data <= i_in_data;
            tail_vld  <= 1'b1;
          end
        end
        2'b01: begin
          head_data <= tail_data;
          head_vld  <= tail_vld;
          tail_vld  <= 1'b0;
        end
        2'b11: begin
          // Occupancy unchanged; order kept by shifting tail into head.
          if (tail_vld) begin
            head_data <= tail_data;
            tail_data <= i_in_data;
          end else begin
            head_data <= i_in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: pops words from a FIFO read port (1-cycle read latency)
// and presents them as a valid/ready stream through a 2-entry buffer.
// A level flush request discards buffered data and drains the FIFO.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   o_pop, i_empty    FIFO read request / empty flag
//   i_rdata           FIFO read data, valid the cycle after an accepted pop
//   i_flush           discard request (level)
//   o_valid, o_data   stream output, i_ready downstream accept
//   o_busy            high while flushing
//   o_word_cnt        words delivered downstream (wraps)
module fifo_pop_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_pop,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_rdata,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [CNTW-1:0]  o_word_cnt
);

  state_t          state;
  logic            inflight;
  logic [CNTW-1:0] word_cnt;

  logic            discard;
  logic            buf_in_valid;
  logic            buf_in_ready;
  logic            buf_out_ready;
  logic [1:0]      buf_count;
  logic            xfer;
  logic [2:0]      occ_sum;
  logic            credit;

  // Anything returned or presented while flushing (or on the request
  // cycle itself) is dropped, including a same-cycle downstream transfer.
  assign discard       = (state == FLUSH) || i_flush;
  assign buf_out_ready = i_ready && !discard;
  assign buf_in_valid  = inflight && buf_in_ready && !discard;
  assign xfer          = o_valid && buf_out_ready;

  // Occupancy plus in-flight pop must stay within the buffer; a word
  // leaving this cycle frees a slot, which keeps 1 word/cycle streaming.
  assign occ_sum = {1'b0, buf_count} + {2'b00, inflight};
  assign credit  = occ_sum < (3'(BUF_DEPTH) + {2'b00, xfer});

  always_comb begin
    o_pop = 1'b0;
    if (i_rst_n && !i_empty) begin
      o_pop = (state == FLUSH) ? 1'b1 : credit;
    end
  end

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (discard),
    .i_in_valid (buf_in_valid),
    .o_in_ready (buf_in_ready),
    .i_in_data  (i_rdata),
    .o_out_valid(o_valid),
    .i_out_ready(buf_out_ready),
    .o_out_data (o_data),
    .o_count    (buf_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= RUN;
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= o_pop;
      if (xfer) begin
        word_cnt <= word_cnt + 1'b1;
      end
      unique case (state)
        RUN: begin
          if (i_flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!i_flush && i_empty && !inflight) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign o_busy     = (state == FLUSH);
  assign o_word_cnt = word_cnt;

endmodule

// File: tb/tb_fifo_pop_stream.sv
// tb_fifo_pop_stream: directed bench for fifo_pop_stream with a simple
// FIFO read-port model (1-cycle read latency) and a stream monitor.
module tb_fifo_pop_stream;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          o_pop;
  logic          i_empty;
  logic [W-1:0]  i_rdata = '0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic          i_ready = 1'b0;
  logic          o_busy;
  logic [CW-1:0] o_word_cnt;

  always #5 i_clk = ~i_clk;

  fifo_pop_stream #(
    .WIDTH(W),
    .CNTW (CW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .o_pop     (o_pop),
    .i_empty   (i_empty),
    .i_rdata   (i_rdata),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_word_cnt(o_word_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // FIFO read-port model: data appears the cycle after an accepted pop.
  logic [W-1:0] fmem [256];
  int wr = 0;
  int rd = 0;
  assign i_empty = (wr == rd);

  always @(posedge i_clk) begin
    if (o_pop && !i_empty) begin
      i_rdata <= fmem[rd];
      rd      <= rd + 1;
    end else begin
      i_rdata <= 16'hDEAD;
    end
  end

  // Stream monitor: a flush request cycle is not a transfer.
  logic [W-1:0] rx_q [$];
  int rx_cyc [$];
  int pop_cyc [$];
  int bad_pop = 0;

  always @(negedge i_clk) begin
    if (o_valid && i_ready && !i_flush) begin
      rx_q.push_back(o_data);
      rx_cyc.push_back(cyc);
    end
    if (o_pop) begin
      if (i_empty) bad_pop++;
      else pop_cyc.push_back(cyc);
    end
  end

  function automatic logic [W-1:0] get_rx(input int idx);
    return (idx < rx_q.size()) ? rx_q[idx] : 16'hFFFF;
  endfunction

  function automatic int get_rx_cyc(input int idx);
    return (idx < rx_cyc.size()) ? rx_cyc[idx] : -1000;
  endfunction

  function automatic int get_pop_cyc(input int idx);
    return (idx < pop_cyc.size()) ? pop_cyc[idx] : 1000;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr] = base + W'(i);
      wr++;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    tick(3);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_rx(input string tag, input int target, input int bound);
    int k = 0;
    while (rx_q.size() < target && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(rx_q.size() >= target), 1);
  endtask

  int rb, pb, hold, vbad, k;

  initial begin
    // Reset held for 3 cycles
    tick(3);
    check("rst_pop", o_pop, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cnt", o_word_cnt, 0);
    i_rst_n = 1'b1;
    tick();

    // Streaming 0x0001..0x0008
    i_ready = 1'b1;
    rb = rx_q.size();
    pb = pop_cyc.size();
    load(8, 16'h0001);
    wait_rx("stream_done", rb + 8, 40);
    for (int i = 0; i < 8; i++) check("stream_data", get_rx(rb + i), 32'(i + 1));
    check("stream_gap", 32'(get_rx_cyc(rb + 7) - get_rx_cyc(rb)), 7);
    check("stream_lat", 32'(get_rx_cyc(rb) - get_pop_cyc(pb)), 2);
    tick(2);
    check("stream_cnt", o_word_cnt, 8);
    check("stream_idle", o_valid, 0);

    // Backpressure: 4 words, i_ready low for 10 cycles
    do_reset();
    rb = rx_q.size();
    pb = pop_cyc.size();
    hold = 0;
    load(4, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_valid && o_data !== 16'h0001) hold++;
    end
    check("bp_pops", 32'(pop_cyc.size() - pb), 2);
    check("bp_valid", o_valid, 1);
    check("bp_data", o_data, 16'h0001);
    check("bp_hold", hold, 0);
    i_ready = 1'b1;
    wait_rx("bp_done", rb + 4, 30);
    for (int i = 0; i < 4; i++) check("bp_order", get_rx(rb + i), 32'(i + 1));
    tick(2);
    check("bp_rx_cnt", 32'(rx_q.size() - rb), 4);
    check("bp_cnt", o_word_cnt, 4);

    // Flush one cycle after the first transfer
    do_reset();
    i_ready = 1'b1;
    rb = rx_q.size();
    load(5, 16'h0011);
    wait_rx("fl_first", rb + 1, 20);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fl_busy", o_busy, 1);
    vbad = 0;
    k = 0;
    while (o_busy && k < 30) begin
      if (o_valid) vbad++;
      tick();
      k++;
    end
    check("fl_exit", o_busy, 0);
    check("fl_vld", vbad, 0);
    check("fl_empty", i_empty, 1);
    check("fl_cnt", o_word_cnt, 1);
    check("fl_rx", 32'(rx_q.size() - rb), 1);
    check("fl_word", get_rx(rb), 16'h0011);
    tick(3);
    check("fl_idle", o_valid, 0);

    // Counter wrap with 4-bit counter: 17 transfers
    do_reset();
    i_ready = 1'b1;
    rb = rx_q.size();
    load(17, 16'h0100);
    wait_rx("wrap_done", rb + 17, 50);
    tick(2);
    check("wrap_cnt", o_word_cnt, 1);
    check("wrap_last", get_rx(rb + 16), 16'h0110);

    // Reset while a pop is in flight
    do_reset();
    i_ready = 1'b1;
    rb = rx_q.size();
    load(1, 16'h0055);
    tick();
    i_rst_n = 1'b0;
    check("mr_pop_rst", o_pop, 0);
    tick(2);
    i_rst_n = 1'b1;
    vbad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_valid) vbad++;
    end
    check("mr_novalid", vbad, 0);
    check("mr_cnt", o_word_cnt, 0);
    check("mr_rx", 32'(rx_q.size() - rb), 0);
    rb = rx_q.size();
    pb = pop_cyc.size();
    load(1, 16'h0077);
    wait_rx("mr_done", rb + 1, 10);
    check("mr_word", get_rx(rb), 16'h0077);
    check("mr_lat", 32'(get_rx_cyc(rb) - get_pop_cyc(pb)), 2);

    check("no_pop_empty", bad_pop, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
